// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and command record for the ALU issue controller.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_ABS = 3'b101;
   localparam logic [2:0] OP_AVG = 3'b110;
   localparam logic [2:0] OP_MOD = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StHold
   } alu_state_e;

   typedef struct packed {
      logic [2:0] inst;
      logic [7:0] a;
      logic [7:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of alu_cmd_t, async active-high reset.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  logic     pop_i,
   input  alu_cmd_t data_i,
   output alu_cmd_t data_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   alu_cmd_t         mem_q [DEPTH];
   logic     [AW:0]  wr_ptr_q;
   logic     [AW:0]  rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator for the ALU: buffers commands, issues them to the ALU, returns tagged results.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk_p_i,
   input  logic             reset_p_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_inst_i,
   input  logic [7:0]       cmd_a_i,
   input  logic [7:0]       cmd_b_i,
   output logic [2:0]       alu_inst_o,
   output logic [7:0]       alu_a_o,
   output logic [7:0]       alu_b_o,
   input  logic [15:0]      alu_data_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [15:0]      res_data_o,
   output logic [TAG_W-1:0] res_tag_o,
   output logic             res_err_o,
   output logic             busy_o
);

   localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   alu_state_e        state_q;
   logic [CntW-1:0]   cnt_q;
   logic [2:0]        inst_q;
   logic [7:0]        a_q;
   logic [7:0]        b_q;
   logic [15:0]       data_q;
   logic              err_q;
   logic              valid_q;
   logic [TAG_W-1:0]  tag_q;

   alu_cmd_t          cmd_in;
   alu_cmd_t          fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   assign cmd_in   = '{inst: cmd_inst_i, a: cmd_a_i, b: cmd_b_i};
   assign fifo_pop = (state_q == StIdle) && !fifo_empty;

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_p_i),
      .rst_i   (reset_p_i),
      .push_i  (cmd_valid_i),
      .pop_i   (fifo_pop),
      .data_i  (cmd_in),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         inst_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fifo_pop) begin
                  inst_q  <= fifo_head.inst;
                  a_q     <= fifo_head.a;
                  b_q     <= fifo_head.b;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               // Modulo by zero never reaches the ALU result path.
               if (inst_q == OP_MOD && a_q == 8'h00) begin
                  data_q  <= 16'h0000;
                  err_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= StHold;
               end else begin
                  cnt_q   <= CntW'(ALU_LAT - 1);
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  data_q  <= alu_data_i;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= StHold;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StHold: begin
               if (res_ready_i) begin
                  valid_q <= 1'b0;
                  tag_q   <= tag_q + 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready_o = !fifo_full;
   assign busy_o      = (state_q != StIdle) || !fifo_empty;
   assign alu_inst_o  = inst_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign res_valid_o = valid_q;
   assign res_data_o  = data_q;
   assign res_tag_o   = tag_q;
   assign res_err_o   = err_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/instruction interface.
- Accepts ALU commands {inst, a, b} over a valid/ready port and buffers them in a small FIFO.
- Drives each command onto the ALU operand bus, waits the ALU's registered latency, then captures the 16-bit result.
- Returns the result, with a sequence tag and an error flag, over a second valid/ready port. Sits between the command source (sequencer or CPU-side logic) and the alu instance.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- ALU_LAT, 1: cycles from operands sampled by the ALU to a valid result on alu_data_i.
- TAG_W, 4: width of the result sequence tag.

Ports:
- clk_p_i  in  1  clock; all logic on rising edge.
- reset_p_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command FIFO can accept.
- cmd_inst_i  in  3  ALU opcode.
- cmd_a_i  in  8  operand A.
- cmd_b_i  in  8  operand B.
- alu_inst_o  out  3  opcode to ALU inst input.
- alu_a_o  out  8  operand A to ALU.
- alu_b_o  out  8  operand B to ALU.
- alu_data_i  in  16  ALU registered result.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumer ready.
- res_data_o  out  16  captured result.
- res_tag_o  out  TAG_W  issue sequence number of this result.
- res_err_o  out  1  divide-by-zero flag.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
Reset:
- All outputs 0 except cmd_ready_o=1 after reset.
- FIFO emptied, tag counter 0, FSM IDLE.
- Reset mid-operation discards in-flight and buffered commands; no partial result is ever presented.

Command port:
- Push when cmd_valid_i && cmd_ready_o.
- cmd_ready_o = !fifo_full. Same-cycle pop does not raise ready.
- Push and pop in the same cycle are both honoured; count unchanged.

FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop and register the head into alu_inst_o/alu_a_o/alu_b_o; go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): operands stable; the ALU samples them at this edge.
  - If inst==3'b111 and a==0 (modulo by zero): capture res_data=16'h0000, res_err=1, go to HOLD.
  - Otherwise load wait counter with ALU_LAT-1 and go to WAIT.
- WAIT (ALU_LAT cycles): operands held. On the last cycle, capture alu_data_i into res_data_o, set res_err_o=0, go to HOLD.
- HOLD: res_valid_o=1; data, tag and err stable until res_ready_i. On handshake: res_valid_o falls next cycle, tag counter increments (wraps 2^TAG_W-1 → 0), go to IDLE.

Operand bus:
- alu_*_o hold their last issued values outside ISSUE/WAIT; they never change during ISSUE/WAIT.

Latency:
- Command pushed at edge E0 into an empty FIFO with FSM IDLE: res_valid_o high after edge E0+2+ALU_LAT.
- Divide-by-zero case: after edge E0+2.
- Throughput: one result per ALU_LAT+3 cycles with res_ready_i held high.

Other rules:
- res_tag_o equals the number of previously completed results mod 2^TAG_W.
- No arithmetic in this block; results pass through from the ALU unmodified.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_AND=011, OP_XOR=100, OP_ABS=101, OP_AVG=110, OP_MOD=111.
  - FSM state typedef.
  - command struct {inst[2:0], a[7:0], b[7:0]}, 19 bits.
- One sub-module: alu_cmd_fifo, a synchronous FIFO of DEPTH × 19 bits with full/empty and an async active-high reset.

Test Plan:
- Single add: inst=000, a=8'h7F, b=8'h01, res_ready_i=1 → res_valid_o after E0+3, res_data_o=16'h0080, tag=0, err=0.
- Subtract then multiply back-to-back: (001, a=3, b=10), then (010, a=8'd12, b=8'd11) → results 16'h0007 tag 0, then 16'h0084 tag 1, in order.
- Modulo by zero: inst=111, a=0, b=5 → res_data_o=16'h0000, res_err_o=1 after E0+2. Next command (111, a=3, b=8) → 16'h0002, err=0.
- Backpressure: res_ready_i=0, push continuously → exactly DEPTH+1=5 commands accepted, then cmd_ready_o=0. res_data_o stays stable until res_ready_i=1, then all five drain in order with tags 0..4.
- Reset mid-WAIT: assert reset_p_i during WAIT with 3 commands queued → all outputs 0 immediately, cmd_ready_o=1 after release, no result ever emitted for the discarded commands, next result carries tag 0.
- Tag wrap: 17 sequential adds → tags 0..15 then 0.
